// File: rtl/hazard_flush_ctrl.sv
// Hazard and flush controller for the 5-stage RV64 pipeline: load-use stall,
// multi-cycle branch flush window, memory-wait freeze, perf counters and watchdog.
module hazard_flush_ctrl #(
    parameter int FLUSH_EXTRA = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs2,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             mem_timeout
);

    localparam int BUSY_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [BUSY_W-1:0] BUSY_LIMIT = BUSY_W'(MEM_TIMEOUT);
    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_EXTRA);

    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] BR_FLUSH = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [3:0]        flush_cnt_reg, flush_cnt_next;
    logic [BUSY_W-1:0] busy_cnt_reg, busy_cnt_next;
    logic              mem_timeout_reg, mem_timeout_next;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;
    logic [1:0]        cnt_inc;

    // x0 is hardwired to zero, so a load into it can never create a hazard
    assign load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        pipe_hold      = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (reset) begin
            pc_write       = 1'b0;
            ifid_write     = 1'b0;
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            state_next     = RUN;
            flush_cnt_next = 4'd0;
        end else if (mem_busy) begin
            // Frozen pipeline: EX/MEM re-presents any branch once the memory is ready
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            stall_inc  = 1'b1;
        end else if (state_reg == BR_FLUSH) begin
            ifid_flush     = 1'b1;
            idex_flush     = 1'b1;
            flush_cnt_next = flush_cnt_reg - 4'd1;
            if (flush_cnt_reg <= 4'd1) begin
                state_next     = RUN;
                flush_cnt_next = 4'd0;
            end
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            if (FLUSH_EXTRA > 0) begin
                state_next     = BR_FLUSH;
                flush_cnt_next = FLUSH_INIT;
            end
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_next = '0;
        if (mem_busy) begin
            busy_cnt_next = (busy_cnt_reg == BUSY_LIMIT) ? busy_cnt_reg
                                                         : busy_cnt_reg + BUSY_W'(1);
        end
        mem_timeout_next = mem_timeout_reg || (busy_cnt_next == BUSY_LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= RUN;
            flush_cnt_reg   <= 4'd0;
            busy_cnt_reg    <= '0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            flush_cnt_reg   <= flush_cnt_next;
            busy_cnt_reg    <= busy_cnt_next;
            mem_timeout_reg <= mem_timeout_next;
        end
    end

    // Index 0 counts stall cycles, index 1 counts accepted taken branches
    assign cnt_inc = {flush_inc, stall_inc};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] count_reg;
        always_ff @(posedge clk) begin
            if (reset) begin
                count_reg <= '0;
            end else if (cnt_inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = g_cnt[0].count_reg;
    assign flush_events = g_cnt[1].count_reg;
    assign mem_timeout  = mem_timeout_reg;

endmodule
